// File: rtl/sram_model_dp_pipe.sv
`default_nettype none
// ============================================================================
// Module  : sram_model_dp_pipe
// Brief   : Behavioural true dual-port SRAM with lane write masks, pipelined
//           reads with per-port QVALID and a write-write collision flag.
// Revision: 1.0 - initial release
// ============================================================================
module sram_model_dp_pipe #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 256,
    parameter int LANE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               CEBA,
    input  logic                               WEBA,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   BWEBA,
    input  logic [ADDR_WIDTH-1:0]              AA,
    input  logic [DATA_WIDTH-1:0]              DA,
    output logic [DATA_WIDTH-1:0]              QA,
    output logic                               QVALIDA,
    input  logic                               CEBB,
    input  logic                               WEBB,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   BWEBB,
    input  logic [ADDR_WIDTH-1:0]              AB,
    input  logic [DATA_WIDTH-1:0]              DB,
    output logic [DATA_WIDTH-1:0]              QB,
    output logic                               QVALIDB,
    output logic                               COLL
);

    localparam int c_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane_width
        $fatal(1, "sram_model_dp_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_read_latency
        $fatal(1, "sram_model_dp_pipe: READ_LATENCY must be in 1..4");
    end

    // Storage is never reset; it starts zeroed and survives RST_N pulses.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH] = '{default: '0};

    logic                  w_bad_a, w_bad_b;
    logic                  w_wr_a, w_rd_a, w_wr_b, w_rd_b;
    logic                  w_same_addr, w_ww_coll;
    logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
    logic [DATA_WIDTH-1:0] w_new_a, w_new_b;
    logic [DATA_WIDTH-1:0] w_rdata_a, w_rdata_b;

    logic [READ_LATENCY-1:0] r_vld_a, r_vld_b;
    logic [DATA_WIDTH-1:0]   r_dat_a [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   r_dat_b [READ_LATENCY];
    logic                    r_coll;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [c_LANES-1:0]    bweb
    );
        logic [DATA_WIDTH-1:0] v_word;
        v_word = old_word;
        for (int i = 0; i < c_LANES; i++) begin
            if (!bweb[i]) begin
                v_word[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return v_word;
    endfunction

    // Unknown control is decoded as idle and flagged separately.
    always_comb begin
        w_bad_a = $isunknown(CEBA) || (CEBA == 1'b0 && $isunknown(WEBA));
        w_bad_b = $isunknown(CEBB) || (CEBB == 1'b0 && $isunknown(WEBB));
        w_wr_a  = !w_bad_a && (CEBA == 1'b0) && (WEBA == 1'b0);
        w_rd_a  = !w_bad_a && (CEBA == 1'b0) && (WEBA == 1'b1);
        w_wr_b  = !w_bad_b && (CEBB == 1'b0) && (WEBB == 1'b0);
        w_rd_b  = !w_bad_b && (CEBB == 1'b0) && (WEBB == 1'b1);
    end

    // Port B merges first so that a same-address A write lands on top of it,
    // giving port A priority on lanes both ports enable.
    always_comb begin
        w_same_addr = (AA == AB);
        w_ww_coll   = w_wr_a && w_wr_b && w_same_addr;
        w_old_a     = r_mem[AA];
        w_old_b     = r_mem[AB];
        w_new_b     = f_merge(w_old_b, DB, BWEBB);
        w_new_a     = f_merge(w_ww_coll ? w_new_b : w_old_a, DA, BWEBA);
        w_rdata_a   = (WRITE_FIRST != 0 && w_wr_b && w_same_addr) ? w_new_b : w_old_a;
        w_rdata_b   = (WRITE_FIRST != 0 && w_wr_a && w_same_addr) ? w_new_a : w_old_b;
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (w_wr_b) begin
                r_mem[AB] <= w_new_b;
            end
            if (w_wr_a) begin
                r_mem[AA] <= w_new_a;
            end
            if (w_bad_a) begin
                $error("sram_model_dp_pipe: X/Z on CEBA/WEBA");
            end
            if (w_bad_b) begin
                $error("sram_model_dp_pipe: X/Z on CEBB/WEBB");
            end
        end
    end

    // Data stages carry zero when empty, so Q is 0 whenever QVALID is 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld_a <= '0;
            r_vld_b <= '0;
            r_coll  <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dat_a[i] <= '0;
                r_dat_b[i] <= '0;
            end
        end else begin
            r_vld_a[0] <= w_rd_a;
            r_vld_b[0] <= w_rd_b;
            r_dat_a[0] <= w_rd_a ? w_rdata_a : '0;
            r_dat_b[0] <= w_rd_b ? w_rdata_b : '0;
            r_coll     <= w_ww_coll;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld_a[i] <= r_vld_a[i-1];
                r_vld_b[i] <= r_vld_b[i-1];
                r_dat_a[i] <= r_dat_a[i-1];
                r_dat_b[i] <= r_dat_b[i-1];
            end
        end
    end

    assign QA      = r_dat_a[READ_LATENCY-1];
    assign QVALIDA = r_vld_a[READ_LATENCY-1];
    assign QB      = r_dat_b[READ_LATENCY-1];
    assign QVALIDB = r_vld_b[READ_LATENCY-1];
    assign COLL    = r_coll;

endmodule
`default_nettype wire
